// File: rtl/csa_batch_ctrl_if.sv
// Operand and result streams between a serial producer/consumer and csa_batch_ctrl.
// Latency: none (wires only). Backpressure: in_ready gates operands; out_ready gates results.
// master = producer/consumer side, slave = controller side.
interface csa_batch_ctrl_if #(
  parameter int W     = 8,
  parameter int OUT_W = 13
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/csa_batch_ctrl.sv
// Buffers up to N_OPS serial operands for the shared csa8x10 adder and returns the registered sum.
// Latency: the result is valid one cycle after the final operand is accepted (FILL -> SUM -> HOLD).
// Backpressure: in_ready low outside FILL; result held until out_ready. CSA_CTRL_ABORT_EN adds abort.
module csa_batch_ctrl #(
  parameter int N_OPS = 10,
  parameter int W     = 8,
  parameter int OUT_W = 13
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef CSA_CTRL_ABORT_EN
  input  logic               abort,
`endif
  csa_batch_ctrl_if.slave    io,
  output logic [N_OPS*W-1:0] csa_data,
  input  logic [OUT_W-1:0]   csa_sum,
  output logic [3:0]         op_count
);

  typedef enum logic [1:0] {FILL, SUM, HOLD} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_OPS - 1);

  state_t           state, state_nxt;
  logic [W-1:0]     slot_q [N_OPS];
  logic [3:0]       cnt_q;
  logic [OUT_W-1:0] sum_q;
  logic             abort_hit;
  logic             accept;
  logic             clear;
  logic             capture;

`ifdef CSA_CTRL_ABORT_EN
  assign abort_hit = abort && (state == FILL);
`else
  assign abort_hit = 1'b0;
`endif

  // Abort takes priority over a coincident operand, which is then dropped.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clear     = 1'b0;
    capture   = 1'b0;
    case (state)
      FILL: begin
        if (abort_hit) begin
          clear = 1'b1;
        end else if (io.in_valid) begin
          accept = 1'b1;
          if ((cnt_q == LAST_IDX) || io.in_last) begin
            state_nxt = SUM;
          end
        end
      end
      SUM: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (io.out_ready) begin
          clear     = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Unfilled slots stay zero, so a short batch sums only the operands it accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OPS; i++) begin
        slot_q[i] <= '0;
      end
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < N_OPS; i++) begin
          slot_q[i] <= '0;
        end
        cnt_q <= '0;
      end else if (accept) begin
        for (int i = 0; i < N_OPS; i++) begin
          if (cnt_q == 4'(i)) begin
            slot_q[i] <= io.in_data;
          end
        end
        cnt_q <= cnt_q + 4'd1;
      end
      if (capture) begin
        sum_q <= csa_sum;
      end
    end
  end

  for (genvar g = 0; g < N_OPS; g++) begin : g_slot
    assign csa_data[W*g +: W] = slot_q[g];
  end

  assign io.in_ready  = (state == FILL);
  assign io.out_valid = (state == HOLD);
  assign io.out_data  = sum_q;
  assign op_count     = cnt_q;

endmodule
